mesi_bus_arbiter: RTL
=====================

Name: mesi_bus_arbiter

Overview:
- Shares the single snooping bus between NUM_CACHES per-cache MESI controllers.
- Picks one requester round-robin, then broadcasts its BusRd/BusRdX/BusUpgr to every other cache.
- Collects their shared (C) and flush responses, then sequences the memory read or write-back.
- Returns shared status and a done pulse to the winner. Sits between the cache MESI FSMs and the memory controller.

Parameters:
- NUM_CACHES, 4, number of requesting caches (2..8).
- ADDR_W, 32, line address width.
- IDX_W, $clog2(NUM_CACHES), requester index width.

Ports:
- clk  in  1  clock.
- rstb  in  1  synchronous reset, active low.
- req  in  NUM_CACHES  per-cache bus request level, held until own done.
- req_op  in  2*NUM_CACHES  per-cache bus_op_t (NONE=0, RD=1, RDX=2, UPGR=3).
- req_addr  in  ADDR_W*NUM_CACHES  per-cache line address.
- gnt  out  NUM_CACHES  one-hot grant, held for the whole transaction.
- bus_valid  out  1  snoop broadcast strobe.
- bus_op  out  2  broadcast op.
- bus_addr  out  ADDR_W  broadcast address.
- bus_src  out  IDX_W  index of the granted cache.
- snoop_c  in  NUM_CACHES  per-cache "line present" response.
- snoop_flush  in  NUM_CACHES  per-cache flush (Modified data) response.
- shared_out  out  1  OR of non-source snoop_c; goes to the requester's C_in.
- done  out  NUM_CACHES  one-cycle completion pulse to the winner.
- mem_rd  out  1  memory line read request.
- mem_wr  out  1  memory write-back of flushed line.
- mem_addr  out  ADDR_W  memory address.
- mem_ack  in  1  memory completion for mem_rd/mem_wr.
- protocol_err  out  1  sticky error flag.

Behaviour:
- All outputs are registered.
- Reset: all outputs 0, state IDLE, rr pointer = NUM_CACHES-1 so cache 0 has first priority.
- Reset mid-transaction aborts it immediately. No done is issued; requesters re-request.
- Valid request: req[i]=1 and req_op[i]!=NONE. A request with req_op=NONE is ignored. No error is raised for it.
- IDLE:
  - If any valid request, choose the first valid index after the rr pointer, wrapping.
  - Latch op, addr and index; set gnt one-hot; go to SNOOP.
  - Requests arriving in other states wait.
- SNOOP (1 cycle): bus_valid=1 with bus_op/bus_addr/bus_src. Next state RESP.
- RESP (1 cycle):
  - Sample snoop_c and snoop_flush, both masked with ~gnt. The source's own responses are ignored.
  - Register shared_out = |(snoop_c & ~gnt).
  - If more than one masked flush bit is set, set protocol_err; this is sticky until reset.
  - If any flush: go to WB.
  - Else if op==UPGR: go to DONE.
  - Else: go to MEM.
- WB:
  - mem_wr=1, mem_addr=latched addr, held until mem_ack.
  - The requester captures the flushed data from the bus; memory is not re-read.
  - On mem_ack go to DONE.
- MEM:
  - mem_rd=1, held until the cycle mem_ack=1.
  - mem_ack may arrive in the same cycle mem_rd first asserts.
  - Then go to DONE.
- DONE (1 cycle):
  - done[src]=1; shared_out stays valid this cycle.
  - Next cycle: gnt=0, rr pointer=src, state IDLE.
  - The requester drops req on the edge that samples done, so IDLE never re-grants a stale request.
- Latency for an uncontested RD, no flush, mem_ack zero-wait: req rises in cycle 0, gnt in 1, bus_valid in 1, done in 4.
- UPGR with no flush: done in cycle 3.
- mem_ack outside WB/MEM is ignored.
- Simultaneous requests are served strictly round-robin, so no starvation. Maximum wait is NUM_CACHES-1 transactions.

Decomposition:
- Package mesi_bus_pkg:
  - bus_op_t enum (NONE, RD, RDX, UPGR).
  - arb_state_t enum (IDLE, SNOOP, RESP, WB, MEM, DONE).
  - Used alongside the existing MESI state struct.
- Sub-module mesi_rr_arbiter: combinational round-robin pick from the valid vector and rr pointer. Returns a one-hot vector and an index.

Test Plan:
- Reset, then req[2]=1 op=RD addr=0x40, no snoop responses, mem_ack on first mem_rd cycle -> gnt=0100 in cycle 1, mem_rd in cycle 3, done[2] in cycle 4, shared_out=0.
- req[1]=1 op=RD; snoop_c=0101 in RESP -> shared_out=1 with done[1]; mem_rd issued; gnt released after done.
- req[0]=1 op=RDX; snoop_flush[3]=1 -> mem_wr with mem_addr=latched addr, no mem_rd, done[0] after mem_ack.
- req[3]=1 op=UPGR; snoop_c=0011 -> no mem_rd/mem_wr, done[3] in cycle 3, shared_out=1.
- req=1111 held continuously, all op=RD -> grant order 0,1,2,3,0, each winner done before the next gnt.
- snoop_flush=0110 in RESP -> protocol_err=1 and stays 1. Assert rstb=0 during MEM -> all outputs 0 next cycle, no done pulse.

Source files
------------

// File: rtl/mesi_bus_pkg.sv
// mesi_bus_pkg: shared types for the snooping-bus arbiter.
//   bus_op_t    - snoop bus operation encoding (matches the cache MESI FSMs)
//   arb_state_t - arbiter transaction state
//   multi_hot() - true when more than one bit of a response vector is set
package mesi_bus_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_RDX  = 2'd2,
    OP_UPGR = 2'd3
  } bus_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNOOP = 3'd1,
    ST_RESP  = 3'd2,
    ST_WB    = 3'd3,
    ST_MEM   = 3'd4,
    ST_DONE  = 3'd5
  } arb_state_t;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/mesi_rr_arbiter.sv
// mesi_rr_arbiter: combinational round-robin pick.
//   valid    - per-cache valid request vector
//   ptr      - index of the last winner; search starts at ptr+1 and wraps
//   any      - at least one valid request
//   pick_oh  - one-hot winner
//   pick_idx - binary index of the winner
module mesi_rr_arbiter #(
  parameter int NUM_CACHES = 4,
  parameter int IDX_W      = $clog2(NUM_CACHES)
) (
  input  logic [NUM_CACHES-1:0] valid,
  input  logic [IDX_W-1:0]      ptr,
  output logic                  any,
  output logic [NUM_CACHES-1:0] pick_oh,
  output logic [IDX_W-1:0]      pick_idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    any      = 1'b0;
    pick_oh  = '0;
    pick_idx = '0;
    cand     = '0;
    // k runs to NUM_CACHES so the last winner itself is considered last.
    for (int k = 1; k <= NUM_CACHES; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_CACHES);
      if (!any && valid[cand]) begin
        any           = 1'b1;
        pick_oh[cand] = 1'b1;
        pick_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// mesi_bus_arbiter: owns the shared snooping bus between NUM_CACHES MESI
// cache controllers and the memory controller.
//   clk, rstb                 - clock, synchronous active-low reset
//   req/req_op/req_addr       - per-cache request level, op and line address
//   gnt                       - one-hot grant for the whole transaction
//   bus_valid/op/addr/src     - snoop broadcast to the other caches
//   snoop_c/snoop_flush       - per-cache snoop responses (source masked)
//   shared_out, done          - shared status and completion pulse to winner
//   mem_rd/mem_wr/mem_addr    - memory line read / flush write-back
//   mem_ack                   - memory completion
//   protocol_err              - sticky: more than one cache flushed a line
//
// state | meaning
// IDLE  | bus free, arbitrate among valid requests
// SNOOP | broadcast strobe on the bus
// RESP  | sample snoop responses, pick next step
// WB    | write flushed line to memory, wait for ack
// MEM   | read line from memory, wait for ack
// DONE  | completion pulse to winner, then release bus
module mesi_bus_arbiter
  import mesi_bus_pkg::*;
#(
  parameter int NUM_CACHES = 4,
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = $clog2(NUM_CACHES)
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic [NUM_CACHES-1:0]        req,
  input  logic [2*NUM_CACHES-1:0]      req_op,
  input  logic [ADDR_W*NUM_CACHES-1:0] req_addr,
  output logic [NUM_CACHES-1:0]        gnt,
  output logic                         bus_valid,
  output logic [1:0]                   bus_op,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic [IDX_W-1:0]             bus_src,
  input  logic [NUM_CACHES-1:0]        snoop_c,
  input  logic [NUM_CACHES-1:0]        snoop_flush,
  output logic                         shared_out,
  output logic [NUM_CACHES-1:0]        done,
  output logic                         mem_rd,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ack,
  output logic                         protocol_err
);

  arb_state_t            state, state_n;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_n;
  logic [NUM_CACHES-1:0] valid;
  logic [1:0]            op_arr   [NUM_CACHES];
  logic [ADDR_W-1:0]     addr_arr [NUM_CACHES];
  logic                  pick_any;
  logic [NUM_CACHES-1:0] pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic [NUM_CACHES-1:0] resp_c, resp_f;

  logic [NUM_CACHES-1:0] gnt_n, done_n;
  logic                  bus_valid_n, shared_n, mem_rd_n, mem_wr_n, err_n;
  logic [1:0]            bus_op_n;
  logic [ADDR_W-1:0]     bus_addr_n, mem_addr_n;
  logic [IDX_W-1:0]      bus_src_n;

  always_comb begin
    for (int i = 0; i < NUM_CACHES; i++) begin
      op_arr[i]   = req_op[2*i +: 2];
      addr_arr[i] = req_addr[ADDR_W*i +: ADDR_W];
      valid[i]    = req[i] && (req_op[2*i +: 2] != OP_NONE);
    end
  end

  mesi_rr_arbiter #(
    .NUM_CACHES (NUM_CACHES),
    .IDX_W      (IDX_W)
  ) u_rr (
    .valid    (valid),
    .ptr      (rr_ptr),
    .any      (pick_any),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

  // The source's own snoop answers are about its own request; drop them.
  assign resp_c = snoop_c & ~gnt;
  assign resp_f = snoop_flush & ~gnt;

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    gnt_n       = gnt;
    bus_valid_n = 1'b0;
    bus_op_n    = bus_op;
    bus_addr_n  = bus_addr;
    bus_src_n   = bus_src;
    shared_n    = shared_out;
    done_n      = '0;
    mem_rd_n    = mem_rd;
    mem_wr_n    = mem_wr;
    mem_addr_n  = mem_addr;
    err_n       = protocol_err;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_n       = pick_oh;
          bus_valid_n = 1'b1;
          bus_op_n    = op_arr[pick_idx];
          bus_addr_n  = addr_arr[pick_idx];
          bus_src_n   = pick_idx;
          state_n     = ST_SNOOP;
        end
      end
      ST_SNOOP: state_n = ST_RESP;
      ST_RESP: begin
        shared_n = |resp_c;
        if (multi_hot(8'(resp_f))) err_n = 1'b1;
        if (|resp_f) begin
          // Requester takes the flushed data off the bus; memory only
          // needs the write-back, never a re-read.
          mem_wr_n   = 1'b1;
          mem_addr_n = bus_addr;
          state_n    = ST_WB;
        end else if (bus_op_t'(bus_op) == OP_UPGR) begin
          done_n  = gnt;
          state_n = ST_DONE;
        end else begin
          mem_rd_n   = 1'b1;
          mem_addr_n = bus_addr;
          state_n    = ST_MEM;
        end
      end
      ST_WB: begin
        if (mem_ack) begin
          mem_wr_n = 1'b0;
          done_n   = gnt;
          state_n  = ST_DONE;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          mem_rd_n = 1'b0;
          done_n   = gnt;
          state_n  = ST_DONE;
        end
      end
      ST_DONE: begin
        gnt_n    = '0;
        rr_ptr_n = bus_src;
        shared_n = 1'b0;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state        <= ST_IDLE;
      rr_ptr       <= IDX_W'(NUM_CACHES - 1);
      gnt          <= '0;
      bus_valid    <= 1'b0;
      bus_op       <= '0;
      bus_addr     <= '0;
      bus_src      <= '0;
      shared_out   <= 1'b0;
      done         <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_n;
      rr_ptr       <= rr_ptr_n;
      gnt          <= gnt_n;
      bus_valid    <= bus_valid_n;
      bus_op       <= bus_op_n;
      bus_addr     <= bus_addr_n;
      bus_src      <= bus_src_n;
      shared_out   <= shared_n;
      done         <= done_n;
      mem_rd       <= mem_rd_n;
      mem_wr       <= mem_wr_n;
      mem_addr     <= mem_addr_n;
      protocol_err <= err_n;
    end
  end

endmodule
